sipo_frame_ctrl: RTL and testbench
==================================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the data bits per word (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the rising-edge clock for all state.
REQ-003 The block SHALL have port reset, input, 1 bit, a synchronous, active-high reset.
REQ-004 The block SHALL have port sof, input, 1 bit, start-of-frame strobe, sampled only when in_valid=1.
REQ-005 The block SHALL have port in_valid, input, 1 bit, qualifying in_bit for the current cycle.
REQ-006 The block SHALL have port in_bit, input, 1 bit, the serial data bit.
REQ-007 The block SHALL have port out_data, output, WIDTH bits, the assembled word.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning out_data holds an unconsumed word.
REQ-009 The block SHALL have port out_ready, input, 1 bit; the consumer accepts the word when out_valid=1 and out_ready=1.
REQ-010 The block SHALL have port overflow, output, 1 bit, a sticky flag set when a completed word is dropped.
REQ-011 The block SHALL have port busy, output, 1 bit, equal to 1 whenever the FSM is not in IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and (macro only) PARITY; all transitions are taken only on cycles with in_valid=1.
REQ-013 In IDLE, sof=1 with in_valid=1 SHALL capture in_bit as bit 0 and move to SHIFT with bit count 1; bits without sof SHALL be ignored.
REQ-014 In SHIFT, each valid bit SHALL be shifted in LSB-first, so the first received bit ends in out_data[0] and the last in out_data[WIDTH-1].
REQ-015 When the WIDTH-th bit is received, the word SHALL be complete; the next state is PARITY if the macro is defined, otherwise SHIFT with count 0 (back-to-back words, no gap).
REQ-016 A complete word SHALL be loaded into the output register on the completing edge if out_valid=0, or if out_valid=1 and out_ready=1 in that same cycle; out_valid is then 1 the cycle after the last bit (latency 1).
REQ-017 If a word completes while out_valid=1 and out_ready=0, the word SHALL be dropped, out_data held unchanged, and overflow set to 1 until reset.
REQ-018 out_valid SHALL clear on handshake unless a new word loads in the same cycle, in which case it stays 1.
REQ-019 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-020 sof=1 with in_valid=1 in SHIFT or PARITY SHALL abort the partial word without flagging, then restart at count 1 with in_bit as bit 0.
REQ-021 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never exceed WIDTH.

Reset
REQ-022 Reset SHALL set: FSM=IDLE, count=0, shift register=0, out_data=0, out_valid=0, overflow=0, busy=0.
REQ-023 Reset asserted mid-word or with out_valid=1 SHALL discard all partial and pending data; the next cycle behaves as after power-up.
REQ-024 Reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-025 When macro SIPO_FRAME_CTRL_PARITY_EN is defined, one extra bit SHALL follow each word in state PARITY; even parity over data+parity bit is required, and a mismatching word SHALL be discarded and counted by output parity_err (1 bit, sticky, reset 0). The FSM then returns to SHIFT with count 0.
REQ-026 When SIPO_FRAME_CTRL_PARITY_EN is undefined, state PARITY and port parity_err SHALL not exist, and words SHALL be WIDTH bits with no gap.

Verification
REQ-027 WIDTH=8, reset, sof with bits 1,0,1,1,0,0,1,0 (one per cycle), out_ready=1 -> out_data=8'h4D, out_valid=1 for exactly one cycle, one cycle after the last bit.
REQ-028 Two back-to-back words 8'hA5 then 8'h3C with out_ready=0 throughout -> out_data stays 8'hA5, overflow=1 after the second word's last bit.
REQ-029 Completing a word in the same cycle as the handshake of the previous word -> out_valid remains 1, out_data updates to the new word, overflow=0.
REQ-030 sof re-asserted after 5 bits, then 8 bits 8'hFF -> out_data=8'hFF, no overflow, with no output from the partial word.
REQ-031 Reset asserted after 4 bits with out_valid=1 -> out_valid=0, busy=0 next cycle; bits without sof are ignored until the next sof.
REQ-032 With PARITY_EN, send 8'h01 followed by parity bit 0 -> word dropped and parity_err=1; send 8'h01 followed by parity bit 1 -> out_data=8'h01.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame assembler: LSB-first words started by sof, single-entry output register with overflow flag.
// Optional per-word even-parity bit enabled by defining SIPO_FRAME_CTRL_PARITY_EN (adds port parity_err).
module sipo_frame_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sof,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    output logic             parity_err,
`endif
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

`ifdef SIPO_FRAME_CTRL_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state, state_nxt;
    logic [CW-1:0]    count, count_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [WIDTH-1:0] out_data_nxt;
    logic             out_valid_nxt;
    logic             overflow_nxt;
    logic             busy_nxt;
    logic             word_done;
    logic             load;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    logic             parity_err_nxt;
`endif

    // Next-state, shift and output-register logic
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        shreg_nxt     = shreg;
        word_done     = 1'b0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
        parity_err_nxt = parity_err;
`endif
        if (in_valid) begin
            if (sof) begin
                // sof always (re)starts a word; any partial word is silently dropped
                state_nxt            = SHIFT;
                count_nxt            = CW'(1);
                shreg_nxt            = '0;
                shreg_nxt[WIDTH-1]   = in_bit;
            end else begin
                case (state)
                    SHIFT: begin
                        // right shift: after WIDTH bits the first bit lands in bit 0
                        shreg_nxt = {in_bit, shreg[WIDTH-1:1]};
                        if (count == CW'(WIDTH - 1)) begin
`ifdef SIPO_FRAME_CTRL_PARITY_EN
                            state_nxt = PARITY;
                            count_nxt = CW'(WIDTH);
`else
                            count_nxt = '0;
                            word_done = 1'b1;
`endif
                        end else begin
                            count_nxt = count + CW'(1);
                        end
                    end
`ifdef SIPO_FRAME_CTRL_PARITY_EN
                    PARITY: begin
                        state_nxt = SHIFT;
                        count_nxt = '0;
                        if (^{shreg, in_bit}) begin
                            parity_err_nxt = 1'b1;
                        end else begin
                            word_done = 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end

        load          = word_done && (!out_valid || out_ready);
        out_data_nxt  = load ? shreg_nxt : out_data;
        overflow_nxt  = overflow | (word_done & out_valid & ~out_ready);
        out_valid_nxt = out_valid;
        if (load) begin
            out_valid_nxt = 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid_nxt = 1'b0;
        end
        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            shreg      <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            shreg      <= shreg_nxt;
            out_data   <= out_data_nxt;
            out_valid  <= out_valid_nxt;
            overflow   <= overflow_nxt;
            busy       <= busy_nxt;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            parity_err <= parity_err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Self-checking bench for sipo_frame_ctrl: vector table, directed corner sequences and random traffic vs a queue-based model.
module tb_sipo_frame_ctrl;

    localparam int unsigned W = 8;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sof = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_bit = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         overflow;
    logic         busy;
`ifdef SIPO_FRAME_CTRL_PARITY_EN
    logic         parity_err;
`endif

    sipo_frame_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .sof       (sof),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
`ifdef SIPO_FRAME_CTRL_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference: bits of the current frame kept in a queue
    bit           m_active;
    bit           m_bits[$];
    bit           m_valid;
    bit [W-1:0]   m_data;
    bit           m_ovf;
    bit           m_perr;

    function automatic void model_step(input bit r, input bit s, input bit v, input bit b, input bit rdy);
        bit         done;
        bit [W-1:0] word;
        int         ones;
        done = 1'b0;
        word = '0;
        if (r) begin
            m_active = 0; m_bits.delete(); m_valid = 0; m_data = '0; m_ovf = 0; m_perr = 0;
            return;
        end
        if (v) begin
            if (s) begin
                m_bits.delete();
                m_bits.push_back(b);
                m_active = 1;
            end else if (m_active) begin
                m_bits.push_back(b);
                if (m_bits.size() == W + (PAR ? 1 : 0)) begin
                    ones = 0;
                    for (int i = 0; i < m_bits.size(); i++) ones += int'(m_bits[i]);
                    for (int i = 0; i < W; i++) word[i] = m_bits[i];
                    m_bits.delete();
                    if (PAR && (ones % 2 != 0)) m_perr = 1;
                    else done = 1;
                end
            end
        end
        if (done && (!m_valid || rdy)) begin
            m_data  = word;
            m_valid = 1;
        end else begin
            if (done) m_ovf = 1;
            if (m_valid && rdy) m_valid = 0;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model, optionally compare all outputs against it
    task automatic cycle(input logic r, input logic s, input logic v, input logic b, input logic rdy, input bit cmp);
        reset = r; sof = s; in_valid = v; in_bit = b; out_ready = rdy;
        model_step(r, s, v, b, rdy);
        @(posedge clk);
        #1;
        if (cmp) begin
            check("rand_out_valid", 32'(out_valid), 32'(m_valid));
            check("rand_out_data",  32'(out_data),  32'(m_data));
            check("rand_overflow",  32'(overflow),  32'(m_ovf));
            check("rand_busy",      32'(busy),      32'(m_active));
`ifdef SIPO_FRAME_CTRL_PARITY_EN
            check("rand_parity_err", 32'(parity_err), 32'(m_perr));
`endif
        end
    endtask

    // Send one word LSB-first (plus its correct parity bit in parity builds); rdy_last applies to the completing bit
    task automatic send_word(input logic [W-1:0] w, input logic first_sof, input logic rdy, input logic rdy_last);
        for (int i = 0; i < W; i++)
            cycle(1'b0, first_sof && (i == 0), 1'b1, w[i], (i == W - 1 && !PAR) ? rdy_last : rdy, 1'b0);
        if (PAR) cycle(1'b0, 1'b0, 1'b1, ^w, rdy_last, 1'b0);
    endtask

    typedef struct {
        logic         rst, s, v, b, rdy;
        logic         ev;
        logic [W-1:0] ed;
        logic         eo, eb;
    } vec_t;

    vec_t       tbl[$];
    logic [W-1:0] pat;

    initial begin
        // Basic word 0x4D from bits 1,0,1,1,0,0,1,0 with out_ready held high
        pat = 8'h4D;
        tbl.push_back('{1, 0, 0, 0, 1, 0, 8'h00, 0, 0});
        for (int i = 0; i < W; i++) begin
            vec_t r;
            r = '{0, (i == 0), 1, pat[i], 1, 0, 8'h00, 0, 1};
            if (i == W - 1 && !PAR) begin r.ev = 1; r.ed = pat; end
            tbl.push_back(r);
        end
        if (PAR) tbl.push_back('{0, 0, 1, 0, 1, 1, 8'h4D, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 8'h4D, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 8'h4D, 0, 1});

        foreach (tbl[k]) begin
            cycle(tbl[k].rst, tbl[k].s, tbl[k].v, tbl[k].b, tbl[k].rdy, 1'b0);
            check($sformatf("vec%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].ev));
            check($sformatf("vec%0d_out_data", k),  32'(out_data),  32'(tbl[k].ed));
            check($sformatf("vec%0d_overflow", k),  32'(overflow),  32'(tbl[k].eo));
            check($sformatf("vec%0d_busy", k),      32'(busy),      32'(tbl[k].eb));
        end

        // Back-to-back words with no consumer: second word dropped, overflow sticks
        cycle(1, 0, 0, 0, 0, 0);
        send_word(8'hA5, 1, 0, 0);
        check("ovf_first_valid", 32'(out_valid), 32'd1);
        check("ovf_first_data",  32'(out_data),  32'hA5);
        check("ovf_first_flag",  32'(overflow),  32'd0);
        send_word(8'h3C, 0, 0, 0);
        check("ovf_second_data", 32'(out_data),  32'hA5);
        check("ovf_second_flag", 32'(overflow),  32'd1);
        check("ovf_second_valid", 32'(out_valid), 32'd1);

        // Word completes on the same edge the previous word is accepted
        cycle(1, 0, 0, 0, 0, 0);
        send_word(8'h11, 1, 0, 0);
        send_word(8'h22, 0, 0, 1);
        check("same_cycle_valid", 32'(out_valid), 32'd1);
        check("same_cycle_data",  32'(out_data),  32'h22);
        check("same_cycle_ovf",   32'(overflow),  32'd0);

        // sof re-asserted mid-word aborts the partial word without a flag
        cycle(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, (i == 0), 1, 1'(i % 2 == 0), 1, 0);
        check("abort_partial_valid", 32'(out_valid), 32'd0);
        send_word(8'hFF, 1, 1, 1);
        check("abort_valid", 32'(out_valid), 32'd1);
        check("abort_data",  32'(out_data),  32'hFF);
        check("abort_ovf",   32'(overflow),  32'd0);

        // Reset mid-word with a pending output discards everything; bits without sof are ignored
        cycle(1, 0, 0, 0, 0, 0);
        send_word(8'h5A, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 0, 0);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        cycle(1, 0, 1, 1, 0, 0);
        check("mid_reset_valid", 32'(out_valid), 32'd0);
        check("mid_reset_busy",  32'(busy),      32'd0);
        check("mid_reset_data",  32'(out_data),  32'd0);
        for (int i = 0; i < 2 * W; i++) cycle(0, 0, 1, 1'(i % 3 == 0), 1, 0);
        check("no_sof_busy",  32'(busy),      32'd0);
        check("no_sof_valid", 32'(out_valid), 32'd0);
        send_word(8'h3C, 1, 1, 1);
        check("after_reset_valid", 32'(out_valid), 32'd1);
        check("after_reset_data",  32'(out_data),  32'h3C);

`ifdef SIPO_FRAME_CTRL_PARITY_EN
        // Odd-parity word dropped and flagged, even-parity word delivered
        cycle(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < W; i++) cycle(0, (i == 0), 1, 1'(i == 0), 1, 0);
        cycle(0, 0, 1, 0, 1, 0);
        check("par_bad_valid", 32'(out_valid),  32'd0);
        check("par_bad_err",   32'(parity_err), 32'd1);
        for (int i = 0; i < W; i++) cycle(0, 0, 1, 1'(i == 0), 1, 0);
        cycle(0, 0, 1, 1, 1, 0);
        check("par_good_valid", 32'(out_valid), 32'd1);
        check("par_good_data",  32'(out_data),  32'h01);
`endif

        // Random traffic against the reference model
        cycle(1, 0, 0, 0, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(199) == 0), 1'($urandom_range(24) == 0),
                  1'($urandom_range(3) != 0), 1'($urandom), 1'($urandom), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
